pipelined_mux_tree: RTL



---
 rtl/mux_tree_pkg.sv | 29 ++
 rtl/mux4_stage.sv | 60 ++++++
 rtl/pipelined_mux_tree.sv | 101 ++++++++++
 3 files changed

// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined radix-4 mux tree.
package mux_tree_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MIN_N_CH  = 4;
  localparam int MAX_N_CH  = 256;

  function automatic int log4(input int n);
    int v;
    int l;
    v = n;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if (v > 1) begin
        v = v / 4;
        l = l + 1;
      end else begin
        v = v;
      end
    end
    return l;
  endfunction

  // A legal channel count is an exact power of four inside the supported range.
  function automatic bit n_ch_legal(input int n);
    return (n >= MIN_N_CH) && (n <= MAX_N_CH) && ((1 << (2 * log4(n))) == n);
  endfunction

endpackage

// File: rtl/mux4_stage.sv
// One registered 4:1 node of the mux tree; consumes select bits [SHIFT+1:SHIFT]
// and carries the full select and valid along with the chosen data.
module mux4_stage
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = 4,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic [SW-1:0]        in_sel,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  output logic                 out_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic [SW-1:0]    sel_d, sel_q;
  logic             valid_d, valid_q;

  // Payload loads only on a valid sample; valid itself always advances.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = in_valid;
    if (in_valid) begin
      sel_d = in_sel;
      case (in_sel[SHIFT +: 2])
        2'd0:    data_d = in_data[0*WIDTH +: WIDTH];
        2'd1:    data_d = in_data[1*WIDTH +: WIDTH];
        2'd2:    data_d = in_data[2*WIDTH +: WIDTH];
        2'd3:    data_d = in_data[3*WIDTH +: WIDTH];
        default: data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
      sel_d  = sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// N_CH:1 radix-4 mux tree, one register stage per tree level.
// Define MUX_TREE_SCAN_EN to let scan_mode substitute an internal select counter.
module pipelined_mux_tree
  import mux_tree_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  N_CH  = 16,
  localparam int SW    = 2 * log4(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [SW-1:0]           in_sel,
  input  logic                    in_valid,
  input  logic                    scan_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SW-1:0]           out_sel,
  output logic                    out_valid
);

  localparam int LEVELS = log4(N_CH);

  if (!n_ch_legal(N_CH) || (WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_cfg
    $fatal(1, "pipelined_mux_tree: N_CH must be a power of 4 in 4..256 and WIDTH in 1..64");
  end

  logic [SW-1:0] sel_eff_s;

`ifdef MUX_TREE_SCAN_EN
  logic [SW-1:0] scan_cnt_d, scan_cnt_q;

  // Counter width equals log2(N_CH), so the natural rollover is the N_CH-1 -> 0 wrap.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (!scan_mode) begin
      scan_cnt_d = '0;
    end else if (in_valid) begin
      scan_cnt_d = scan_cnt_q + SW'(1);
    end else begin
      scan_cnt_d = scan_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign sel_eff_s = scan_mode ? scan_cnt_q : in_sel;
`else
  logic unused_scan_mode_s;
  assign unused_scan_mode_s = scan_mode;
  assign sel_eff_s          = in_sel;
`endif

  // Level 0 is the raw channel bus; level k+1 holds the outputs of tree stage k.
  logic [WIDTH-1:0] lvl_data_s  [LEVELS+1][N_CH];
  logic [SW-1:0]    lvl_sel_s   [LEVELS+1][N_CH];
  logic             lvl_valid_s [LEVELS+1][N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_in
    assign lvl_data_s[0][i]  = in_data[i*WIDTH +: WIDTH];
    assign lvl_sel_s[0][i]   = sel_eff_s;
    assign lvl_valid_s[0][i] = in_valid;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NODES = N_CH >> (2 * (k + 1));
    for (genvar j = 0; j < N_CH; j++) begin : g_node
      if (j < NODES) begin : g_mux
        mux4_stage #(
          .WIDTH (WIDTH),
          .SW    (SW),
          .SHIFT (2 * k)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .in_data   ({lvl_data_s[k][4*j+3], lvl_data_s[k][4*j+2],
                       lvl_data_s[k][4*j+1], lvl_data_s[k][4*j]}),
          .in_sel    (lvl_sel_s[k][4*j]),
          .in_valid  (lvl_valid_s[k][4*j]),
          .out_data  (lvl_data_s[k+1][j]),
          .out_sel   (lvl_sel_s[k+1][j]),
          .out_valid (lvl_valid_s[k+1][j])
        );
      end else begin : g_idle
        assign lvl_data_s[k+1][j]  = '0;
        assign lvl_sel_s[k+1][j]   = '0;
        assign lvl_valid_s[k+1][j] = 1'b0;
      end
    end
  end

  assign out_data  = lvl_data_s[LEVELS][0];
  assign out_sel   = lvl_sel_s[LEVELS][0];
  assign out_valid = lvl_valid_s[LEVELS][0];

endmodule
